if_id_queue: RTL

Instruction queue between the fetch stage and the decode stage.
- Captures each valid {pc, instruction} pair presented by fetch (instruction returned by instruction memory for the current iaddr) into a small in-order FIFO.
- Presents the oldest entry to decode with a valid/ready handshake.
- Back-pressures fetch via if_stall when full.
- Discards all buffered entries on flush (branch/exception redirect).

---
 rtl/if_id_queue.sv | 76 +++++++
 1 files changed

// File: rtl/if_id_queue.sv
// In-order fetch-to-decode instruction queue: buffers {pc, inst} pairs from fetch,
// presents the oldest to decode via valid/ready, and discards everything on flush.
module if_id_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_inst,
  output logic             if_ready,
  output logic             if_stall,
  output logic             id_valid,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_inst,
  input  logic             id_ready,
  output logic [PTR_W:0]   count
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;

  // Handshake flags decode registered occupancy only; no path from id_ready to if_ready.
  always_comb begin
    if_ready = (cnt != CNT_FULL);
    if_stall = ~if_ready;
    id_valid = (cnt != '0);
    id_pc    = id_valid ? pc_mem[rptr]   : 32'h0000_0000;
    id_inst  = id_valid ? inst_mem[rptr] : 32'h0000_0000;
    count    = cnt;
    push     = if_valid & if_ready & ~flush;
    pop      = id_valid & id_ready & ~flush;
  end

  // Pointer and occupancy state; reset outranks flush, flush outranks push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      if (push && !pop)      cnt <= cnt + CNT_W'(1);
      else if (pop && !push) cnt <= cnt - CNT_W'(1);
    end
  end

  // Entry storage, cleared on reset so the head reads zero until refilled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wptr]   <= if_pc;
      inst_mem[wptr] <= if_inst;
    end
  end

endmodule
